rx_sm: RTL and testbench

- Receiving end of the synchronous serial byte link; pairs with the transmit state machine.
- Advertises readiness with rx_ready and deserialises 8 bits LSB-first while tx_valid is high.
- Commits each byte on the transmitter's address-increment beat (9th tx_valid cycle) into a small first-word-fall-through buffer drained by the local consumer.
- Tracks end of transfer (tx_finish), framing errors and overflow.

---
 rtl/rx_pkg.sv | 14 +
 rtl/rx_sm_if.sv | 12 +
 rtl/rx_fifo.sv | 58 +++++
 rtl/rx_sm.sv | 135 +++++++++++++
 tb/tb_rx_sm.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/rx_pkg.sv
// Shared types and default sizing for the serial byte receiver.
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2,
    DONE = 2'd3
  } rx_state_e;

  localparam int RX_DATA_W = 8;
  localparam int RX_DEPTH  = 4;

endpackage

// File: rtl/rx_sm_if.sv
// Serial link between the transmit and receive state machines.
interface rx_sm_if;

  logic tx_data;
  logic tx_valid;
  logic tx_finish;
  logic rx_ready;

  modport master (output tx_data, output tx_valid, output tx_finish, input rx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_finish, output rx_ready);

endinterface

// File: rtl/rx_fifo.sv
// First-word-fall-through receive buffer; head entry is presented
// combinationally and reads as zero while the buffer is empty.
module rx_fifo
  import rx_pkg::*;
#(
  parameter int DATA_W = RX_DATA_W,
  parameter int DEPTH  = RX_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  // A write into a full buffer or a pop from an empty one is dropped.
  assign wr_ok    = wr_en && !full;
  assign rd_ok    = rd_en && !rd_empty;
  assign rd_empty = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign rd_data  = rd_empty ? '0 : mem[rd_ptr];

  // Storage array; contents are only meaningful behind valid pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rx_sm.sv
// Receive state machine: deserialises LSB-first frames from the link,
// commits each byte on the beat after the last data bit, and reports
// end of transfer, framing errors and overflow.
module rx_sm
  import rx_pkg::*;
#(
  parameter int DATA_W = RX_DATA_W,
  parameter int DEPTH  = RX_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rx_sm_if.slave                 link,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   rx_done,
  input  logic                   rx_clr,
  output logic                   frame_err,
  output logic                   overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(DATA_W + 1);

  rx_state_e         state;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic              ready;
  logic              full;
  logic              commit;
  logic              pop;
  logic [CW-1:0]     count_nxt;
  logic              full_nxt;

  assign link.rx_ready = ready;

  // Commit beat: the extra strobe after DATA_W data bits carries no data.
  assign commit    = (state == RECV) && link.tx_valid &&
                     (bit_cnt == BW'(DATA_W)) && !rx_clr;
  assign pop       = rd_en && !rd_empty;
  // Look-ahead occupancy so the registered ready matches the buffer
  // state in the same cycle the FSM lands in IDLE.
  assign count_nxt = count + CW'(commit) - CW'(pop);
  assign full_nxt  = (count_nxt == CW'(DEPTH));

  rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (commit),
    .wr_data  (shreg),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_empty (rd_empty),
    .full     (full),
    .count    (count)
  );

  // Frame FSM with registered ready, done and single-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      ready     <= 1'b0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      if (rx_clr) begin
        // Abandons any partial frame silently; buffer is left intact.
        state   <= IDLE;
        bit_cnt <= '0;
        rx_done <= 1'b0;
        ready   <= !full_nxt;
      end else begin
        case (state)
          IDLE: begin
            if (link.tx_finish) begin
              state   <= DONE;
              rx_done <= 1'b1;
              ready   <= 1'b0;
            end else if (link.tx_valid && full) begin
              overflow <= 1'b1;
              state    <= DROP;
              ready    <= 1'b0;
            end else if (link.tx_valid) begin
              shreg   <= {link.tx_data, shreg[DATA_W-1:1]};
              bit_cnt <= BW'(1);
              state   <= RECV;
              ready   <= 1'b0;
            end else begin
              ready <= !full_nxt;
            end
          end
          RECV: begin
            if (!link.tx_valid) begin
              frame_err <= 1'b1;
              bit_cnt   <= '0;
              state     <= IDLE;
              ready     <= !full_nxt;
            end else if (bit_cnt == BW'(DATA_W)) begin
              bit_cnt <= '0;
              state   <= IDLE;
              ready   <= !full_nxt;
            end else begin
              shreg   <= {link.tx_data, shreg[DATA_W-1:1]};
              bit_cnt <= bit_cnt + BW'(1);
              ready   <= 1'b0;
            end
          end
          DROP: begin
            if (!link.tx_valid) begin
              state <= IDLE;
              ready <= !full_nxt;
            end else begin
              ready <= 1'b0;
            end
          end
          DONE: begin
            rx_done <= 1'b1;
            ready   <= 1'b0;
          end
          default: begin
            state <= IDLE;
            ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_sm.sv
// Directed and randomised bench for the serial byte receiver, checked
// against a queue model of the receive buffer.
module tb_rx_sm;

  localparam int DW  = 8;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_en = 1'b0;
  logic          rx_clr = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_empty;
  logic [2:0]    count;
  logic          rx_done;
  logic          frame_err;
  logic          overflow;

  rx_sm_if link();

  always #5 clk = ~clk;

  rx_sm #(.DATA_W(DW), .DEPTH(DEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .link      (link),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_empty  (rd_empty),
    .count     (count),
    .rx_done   (rx_done),
    .rx_clr    (rx_clr),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  int            checks = 0;
  int            failures = 0;
  int            fin_beat = -1;
  logic [DW-1:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] head();
    return (q.size() > 0) ? q[0] : '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_buf(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(q.size()));
    chk({tag, "_empty"}, 32'(rd_empty), 32'(q.size() == 0));
    chk({tag, "_head"}, 32'(rd_data), 32'(head()));
  endtask

  task automatic pop_one();
    chk("pop_head", 32'(rd_data), 32'(head()));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    check_buf("pop");
  endtask

  task automatic data_beats(input logic [DW-1:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      link.tx_valid  = 1'b1;
      link.tx_data   = d[i];
      link.tx_finish = (i == fin_beat);
      tick();
      chk("ready_busy", 32'(link.rx_ready), 32'd0);
    end
    link.tx_finish = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pop_on_commit);
    chk("ready_pre", 32'(link.rx_ready), 32'd1);
    data_beats(d, DW);
    link.tx_valid = 1'b1;
    link.tx_data  = 1'($urandom_range(0, 1));
    rd_en = pop_on_commit;
    tick();
    rd_en = 1'b0;
    if (pop_on_commit && q.size() > 0) void'(q.pop_front());
    q.push_back(d);
    check_buf("commit");
    chk("commit_ferr", 32'(frame_err), 32'd0);
    chk("commit_ovf", 32'(overflow), 32'd0);
    chk("ready_post", 32'(link.rx_ready), 32'(q.size() < DEP));
    link.tx_valid = 1'b0;
    tick();
    chk("ready_gap", 32'(link.rx_ready), 32'(q.size() < DEP));
  endtask

  initial begin
    logic [DW-1:0] b;
    link.tx_data = 1'b0;
    link.tx_valid = 1'b0;
    link.tx_finish = 1'b0;

    // Reset state
    tick();
    tick();
    check_buf("rst");
    chk("rst_ready", 32'(link.rx_ready), 32'd0);
    chk("rst_done", 32'(rx_done), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", 32'(link.rx_ready), 32'd1);

    // First frame 0xA5
    send_frame(8'hA5, 1'b0);
    chk("a5_data", 32'(rd_data), 32'hA5);
    pop_one();

    // Four frames then end of transfer; tx_finish in RECV is ignored
    fin_beat = 3;
    send_frame(8'h01, 1'b0);
    fin_beat = -1;
    chk("fin_in_recv", 32'(rx_done), 32'd0);
    send_frame(8'h80, 1'b0);
    send_frame(8'hFF, 1'b0);
    send_frame(8'h3C, 1'b0);
    chk("full_ready", 32'(link.rx_ready), 32'd0);
    link.tx_finish = 1'b1;
    tick();
    link.tx_finish = 1'b0;
    chk("done_set", 32'(rx_done), 32'd1);
    chk("done_ready", 32'(link.rx_ready), 32'd0);
    for (int i = 0; i < 4; i++) pop_one();
    chk("done_held", 32'(rx_done), 32'd1);
    chk("done_ready_empty", 32'(link.rx_ready), 32'd0);
    rx_clr = 1'b1;
    tick();
    rx_clr = 1'b0;
    chk("clr_done", 32'(rx_done), 32'd0);
    chk("clr_ready", 32'(link.rx_ready), 32'd1);

    // Frame error after five data beats
    data_beats(8'($urandom), 5);
    link.tx_valid = 1'b0;
    tick();
    chk("ferr_pulse", 32'(frame_err), 32'd1);
    chk("ferr_ready", 32'(link.rx_ready), 32'd1);
    check_buf("ferr");
    tick();
    chk("ferr_clear", 32'(frame_err), 32'd0);

    // Randomised frames and pops
    for (int it = 0; it < 12; it++) begin
      if (q.size() < DEP && $urandom_range(0, 2) != 0) send_frame(8'($urandom), 1'b0);
      else pop_one();
    end
    while (q.size() < DEP) send_frame(8'($urandom), 1'b0);

    // Overflow with buffer full
    for (int i = 0; i < DW + 1; i++) begin
      link.tx_valid = 1'b1;
      link.tx_data  = 1'($urandom_range(0, 1));
      tick();
      chk("ovf_pulse", 32'(overflow), 32'(i == 0));
      chk("ovf_ready", 32'(link.rx_ready), 32'd0);
      check_buf("ovf");
    end
    link.tx_valid = 1'b0;
    tick();
    chk("ovf_idle_ready", 32'(link.rx_ready), 32'd0);
    chk("ovf_ferr", 32'(frame_err), 32'd0);
    pop_one();
    chk("ovf_pop_ready", 32'(link.rx_ready), 32'd1);
    pop_one();

    // Simultaneous commit and pop at count=2
    b = 8'($urandom);
    send_frame(b, 1'b1);
    chk("simul_count", 32'(count), 32'd2);
    pop_one();
    chk("simul_tail", 32'(rd_data), 32'(b));

    // Reset during beat 4 of a frame
    data_beats(8'($urandom), 3);
    link.tx_valid = 1'b1;
    link.tx_data  = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    q.delete();
    check_buf("mid_rst");
    chk("mid_rst_ready", 32'(link.rx_ready), 32'd0);
    chk("mid_rst_done", 32'(rx_done), 32'd0);
    link.tx_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rel_ready", 32'(link.rx_ready), 32'd1);
    b = 8'($urandom);
    send_frame(b, 1'b0);
    chk("post_rst_data", 32'(rd_data), 32'(b));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
